// File: rtl/uart_tx_buf.sv
// uart_tx_buf: byte FIFO feeding a UART transmitter through its enable/busy
// handshake. It stores producer bytes in a circular buffer and launches them
// one at a time. It also reports fill level and sticky overflow.
module uart_tx_buf #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [7:0]        wr_data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o,
  input  logic              uart_tx_busy_i,
  output logic              uart_tx_en_o,
  output logic [7:0]        uart_txdata_o
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_WAIT_FALL = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);

  logic [7:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_nxt_s;
  logic              full_r;
  logic              empty_r;
  logic              overflow_r;
  logic              tx_en_r;
  logic [7:0]        txdata_r;
  state_t            state_r;
  state_t            state_nxt_s;
  logic              launch_s;
  logic              push_s;
  logic              drop_s;

  // Push acceptance looks only at the registered full flag, so a pop in the
  // same cycle cannot make room for a push that arrived while full.
  assign push_s = wr_en_i & ~full_r & ~flush_i;
  assign drop_s = wr_en_i &  full_r & ~flush_i;

  // Next fill level: push and pop in the same cycle cancel out.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, launch_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Launch sequencer next state: launch from IDLE only, then wait for busy to rise and fall.
  always_comb begin
    state_nxt_s = state_r;
    launch_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_r && !uart_tx_busy_i && !flush_i) begin
          launch_s    = 1'b1;
          state_nxt_s = ST_WAIT_RISE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_RISE: begin
        if (uart_tx_busy_i) begin
          state_nxt_s = ST_WAIT_FALL;
        end else begin
          state_nxt_s = ST_WAIT_RISE;
        end
      end
      ST_WAIT_FALL: begin
        if (!uart_tx_busy_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_FALL;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register; flush leaves it alone so an in-flight byte completes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Storage array write port; contents need no reset because the pointers define validity.
  always_ff @(posedge sys_clk) begin
    if (push_s && !sys_rst) begin
      mem_r[wr_ptr_r] <= wr_data_i;
    end
  end

  // Pointers, flags and the registered transmitter interface.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
      tx_en_r    <= 1'b0;
      txdata_r   <= 8'h00;
    end else if (flush_i) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
      tx_en_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (launch_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        txdata_r <= mem_r[rd_ptr_r];
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      empty_r <= (count_nxt_s == CNT_ZERO);
      tx_en_r <= launch_s;
    end
  end

  assign full_o        = full_r;
  assign empty_o       = empty_r;
  assign count_o       = count_r;
  assign overflow_o    = overflow_r;
  assign uart_tx_en_o  = tx_en_r;
  assign uart_txdata_o = txdata_r;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: a queue-based reference model plus a small
// transmitter model. The model is checked every cycle, and directed
// scenarios carry literal expectations.
module tb_uart_tx_buf;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int FRAME  = 3;

  logic              sys_clk;
  logic              sys_rst;
  logic              flush_i;
  logic              wr_en_i;
  logic [7:0]        wr_data_i;
  logic              full_o;
  logic              empty_o;
  logic [ADDR_W:0]   count_o;
  logic              overflow_o;
  logic              uart_tx_busy_i;
  logic              uart_tx_en_o;
  logic [7:0]        uart_txdata_o;

  int checks = 0;
  int errors = 0;

  // transmitter model state
  logic tx_hold;
  logic tx_busy_m;
  logic start_pending;
  int   busy_left;

  // reference model state
  logic [7:0] m_q[$];
  logic       m_ovf;
  logic       m_en;
  logic [7:0] m_data;
  logic       m_ready;
  logic       m_rise;
  logic       m_launch;
  logic       m_full;

  logic [7:0] sent_log[$];
  logic [7:0] pat;

  uart_tx_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .flush_i       (flush_i),
    .wr_en_i       (wr_en_i),
    .wr_data_i     (wr_data_i),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o),
    .uart_tx_busy_i(uart_tx_busy_i),
    .uart_tx_en_o  (uart_tx_en_o),
    .uart_txdata_o (uart_txdata_o)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: advance the transmitter model, then drive the producer inputs.
  task automatic step(input logic wr, input logic [7:0] d, input logic fl);
    @(negedge sys_clk);
    if (start_pending) begin
      tx_busy_m     = 1'b1;
      busy_left     = FRAME;
      start_pending = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy_m = 1'b0;
    end
    if (uart_tx_en_o === 1'b1) start_pending = 1'b1;
    uart_tx_busy_i = tx_busy_m | tx_hold;
    wr_en_i   = wr;
    wr_data_i = d;
    flush_i   = fl;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst        = 1'b1;
    tx_hold        = 1'b0;
    tx_busy_m      = 1'b0;
    start_pending  = 1'b0;
    busy_left      = 0;
    uart_tx_busy_i = 1'b0;
    wr_en_i        = 1'b0;
    flush_i        = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    sys_rst = 1'b0;
  endtask

  // Reference model: advances on each rising edge, then compares all outputs.
  initial begin
    forever begin
      @(posedge sys_clk);
      if (sys_rst) begin
        m_q.delete();
        m_ovf   = 1'b0;
        m_en    = 1'b0;
        m_data  = 8'h00;
        m_ready = 1'b1;
        m_rise  = 1'b0;
      end else begin
        m_launch = m_ready && (m_q.size() != 0) && !uart_tx_busy_i && !flush_i;
        if (m_launch) begin
          m_ready = 1'b0;
          m_rise  = 1'b0;
        end else if (!m_ready) begin
          if (!m_rise) begin
            if (uart_tx_busy_i) m_rise = 1'b1;
          end else if (!uart_tx_busy_i) begin
            m_ready = 1'b1;
          end
        end
        if (flush_i) begin
          m_q.delete();
          m_ovf = 1'b0;
          m_en  = 1'b0;
        end else begin
          m_full = (m_q.size() == DEPTH);
          m_en   = m_launch;
          if (m_launch) m_data = m_q.pop_front();
          if (wr_en_i) begin
            if (m_full) m_ovf = 1'b1;
            else m_q.push_back(wr_data_i);
          end
        end
      end
      #1;
      chk("count_o",       32'(count_o),       32'(m_q.size()));
      chk("empty_o",       32'(empty_o),       32'(m_q.size() == 0));
      chk("full_o",        32'(full_o),        32'(m_q.size() == DEPTH));
      chk("overflow_o",    32'(overflow_o),    32'(m_ovf));
      chk("uart_tx_en_o",  32'(uart_tx_en_o),  32'(m_en));
      chk("uart_txdata_o", 32'(uart_txdata_o), 32'(m_data));
      if (uart_tx_en_o === 1'b1) sent_log.push_back(uart_txdata_o);
    end
  end

  initial begin
    sys_rst        = 1'b1;
    wr_en_i        = 1'b1;
    wr_data_i      = 8'h55;
    flush_i        = 1'b0;
    tx_hold        = 1'b0;
    tx_busy_m      = 1'b0;
    start_pending  = 1'b0;
    busy_left      = 0;
    uart_tx_busy_i = 1'b0;

    // Reset held 3 cycles with a push request active
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    sys_rst = 1'b0;
    wr_en_i = 1'b0;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full",  32'(full_o),  32'd0);
    chk("rst_ovf",   32'(overflow_o), 32'd0);
    chk("rst_en",    32'(uart_tx_en_o), 32'd0);
    chk("rst_data",  32'(uart_txdata_o), 32'h00);

    // Single byte: launch one cycle after the push
    sent_log.delete();
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("single_empty", 32'(empty_o), 32'd0);
    chk("single_en_early", 32'(uart_tx_en_o), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("single_en", 32'(uart_tx_en_o), 32'd1);
    chk("single_data", 32'(uart_txdata_o), 32'hA5);
    chk("single_count", 32'(count_o), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("single_en_fall", 32'(uart_tx_en_o), 32'd0);
    repeat (10) step(1'b0, 8'h00, 1'b0);
    chk("single_pulses", 32'(sent_log.size()), 32'd1);

    // Fill to full with busy held high, then drain
    sent_log.delete();
    tx_hold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 16) begin
        chk("fill_full16", 32'(full_o), 32'd1);
        chk("fill_ovf16",  32'(overflow_o), 32'd0);
      end
    end
    step(1'b0, 8'h00, 1'b0);
    chk("fill_ovf17",   32'(overflow_o), 32'd1);
    chk("fill_count17", 32'(count_o), 32'd16);
    tx_hold = 1'b0;
    repeat (150) step(1'b0, 8'h00, 1'b0);
    chk("fill_pulses", 32'(sent_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < sent_log.size(); i++) begin
      chk("fill_order", 32'(sent_log[i]), 32'(i));
    end
    chk("fill_drained", 32'(count_o), 32'd0);

    // Push while full with a simultaneous pop
    do_reset();
    sent_log.delete();
    tx_hold = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("pf_full", 32'(full_o), 32'd1);
    tx_hold = 1'b0;
    step(1'b1, 8'hEE, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("pf_count", 32'(count_o), 32'd15);
    chk("pf_ovf",   32'(overflow_o), 32'd1);
    chk("pf_en",    32'(uart_tx_en_o), 32'd1);
    chk("pf_data",  32'(uart_txdata_o), 32'h20);
    repeat (120) step(1'b0, 8'h00, 1'b0);
    chk("pf_pulses", 32'(sent_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < sent_log.size(); i++) begin
      chk("pf_order", 32'(sent_log[i]), 32'(8'h20 + i));
    end

    // Wrap-around: 40 paced bytes
    do_reset();
    sent_log.delete();
    for (int i = 0; i < 40; i++) begin
      pat = 8'((i * 37 + 11) & 255);
      step(1'b1, pat, 1'b0);
      repeat (4) step(1'b0, 8'h00, 1'b0);
    end
    repeat (100) step(1'b0, 8'h00, 1'b0);
    chk("wrap_pulses", 32'(sent_log.size()), 32'd40);
    for (int i = 0; i < 40 && i < sent_log.size(); i++) begin
      pat = 8'((i * 37 + 11) & 255);
      chk("wrap_order", 32'(sent_log[i]), 32'(pat));
    end
    chk("wrap_ovf", 32'(overflow_o), 32'd0);

    // Flush mid-transfer together with a push
    do_reset();
    sent_log.delete();
    tx_hold = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
    tx_hold = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("fl_launch", 32'(uart_tx_en_o), 32'd1);
    chk("fl_count4", 32'(count_o), 32'd4);
    step(1'b1, 8'h99, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("fl_count", 32'(count_o), 32'd0);
    chk("fl_empty", 32'(empty_o), 32'd1);
    chk("fl_ovf",   32'(overflow_o), 32'd0);
    repeat (30) step(1'b0, 8'h00, 1'b0);
    chk("fl_pulses", 32'(sent_log.size()), 32'd1);
    if (sent_log.size() > 0) chk("fl_byte", 32'(sent_log[0]), 32'h50);
    chk("fl_busy_done", 32'(uart_tx_busy_i), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
